cdc_handshake_tx: RTL and testbench
===================================

// Module: cdc_handshake_tx
// PURPOSE
//  Source-domain (clk) sender of a 4-phase req/ack multi-bit clock-domain crossing.
//  - Accepts one word on a valid/ready port and holds it on tx_data.
//  - Raises tx_req and waits for the destination's rx_ack, which arrives asynchronously.
//  - rx_ack is synchronised into clk through a 2-flop sync_flop.
//  - Pairs with a destination-side receiver, which samples tx_data after synchronising tx_req.
// PARAMETERS
//  DATA_W    32    width of the transferred word
//  CNT_W     16    width of the completed-transfer counter (wraps)
//  TIMEOUT   1023  clk cycles spent in a wait state before timeout_err is set; 0 disables it
//  TO_W      10    width of the timeout counter; TIMEOUT must be < 2**TO_W
// PORTS
//  clk          in   1       source-domain clock
//  rst          in   1       reset, asynchronous, active-high
//  s_valid      in   1       upstream word valid
//  s_data       in   DATA_W  upstream word
//  s_ready      out  1       block can accept a word
//  tx_req       out  1       request to the destination domain; driven directly by a flop
//  tx_data      out  DATA_W  held word; driven directly by a flop
//  rx_ack       in   1       acknowledge from the destination domain (asynchronous)
//  busy         out  1       a transfer is in progress (state != IDLE)
//  xfer_count   out  CNT_W   number of completed 4-phase transfers
//  timeout_err  out  1       sticky: a wait state exceeded TIMEOUT
// BEHAVIOUR
//  Reset values: all outputs, the FSM and ack_s are cleared.
//   - s_ready=0 while rst is asserted. After release it follows the IDLE rule below.
//   - tx_req=0, tx_data=0, busy=0, xfer_count=0, timeout_err=0, FSM=IDLE, ack_s=0.
//  ack_s is rx_ack after two clk flops (sync_flop, WIDTH=1), i.e. 2-3 cycles of latency.
//  FSM states (registered) and transitions:
//   - IDLE:  s_ready = ~ack_s.
//            On s_valid && s_ready: tx_data <= s_data, tx_req <= 1, go REQ.
//            tx_req is therefore high on the cycle after the handshake.
//   - REQ:   tx_req=1, s_ready=0. On ack_s==1: tx_req <= 0, go ACKLO.
//   - ACKLO: tx_req=0, s_ready=0. On ack_s==0: xfer_count <= xfer_count+1 (wraps), go IDLE.
//            The word can be accepted one cycle after this transition.
//  tx_data stability:
//   - Loaded only on the IDLE handshake.
//   - Constant from tx_req rising until ack_s is seen low in ACKLO.
//  Minimum transfer time: 1 + 2*(2..3 sync) + protocol cycles (about 6 clk at zero destination delay).
//  Timeout:
//   - to_cnt clears on every state change and counts clk cycles spent in REQ or ACKLO.
//   - When to_cnt == TIMEOUT: timeout_err <= 1 (sticky until rst); to_cnt saturates.
//   - The FSM keeps waiting; nothing is aborted.
//  Boundary conditions:
//   - ack_s high while in IDLE (destination still ending the previous cycle, or a stray ack):
//     s_ready=0, nothing is accepted, no error is flagged.
//   - s_valid deasserting in REQ or ACKLO has no effect. s_data is only sampled on the handshake.
//   - s_valid held high continuously: back-to-back transfers, one per full 4-phase cycle.
//   - rst asserted mid-transfer: immediately returns to the reset values.
//     The destination must also be reset, otherwise its pending ack simply blocks IDLE until it drops.
//   - xfer_count wraps from 2**CNT_W-1 to 0 without any flag.
// STRUCTURE
//  Package cdc_pkg:
//   - typedef of the state enum: IDLE=2'd0, REQ=2'd1, ACKLO=2'd2 (2'd3 is illegal and returns to IDLE).
//   - shared constant SYNC_STAGES=2.
//  Sub-module: one sync_flop instance (WIDTH=1) for rx_ack.
//  Everything else lives in one sequential process plus one combinational s_ready assignment.
// TESTING
//  1. Reset, then s_valid=1, s_data=32'hDEADBEEF for one cycle.
//     -> tx_req rises 1 cycle later, tx_data=32'hDEADBEEF.
//     A responder acks after 3 cycles and releases after req falls.
//     -> xfer_count=1, busy=0, s_ready=1.
//  2. s_valid held high with data 1,2,3.
//     -> three transfers in order, tx_data never changes while tx_req=1 or ack_s=1, xfer_count=3.
//  3. Hold rx_ack=1 in IDLE (stray ack).
//     -> s_ready=0 and no tx_req. Release rx_ack.
//     -> s_ready=1 after 2-3 cycles.
//  4. TIMEOUT=8, responder never acks.
//     -> timeout_err=1 after about 9 cycles in REQ, tx_req stays 1.
//     A late ack then completes the transfer normally and timeout_err stays 1.
//  5. Assert rst while in ACKLO.
//     -> tx_req=0, busy=0, xfer_count=0, timeout_err=0 at once; a new transfer then succeeds.
//  6. CNT_W=4, run 17 transfers.
//     -> xfer_count wraps 15->0 and reads 1 at the end.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types and constants for the req/ack clock-domain crossing blocks.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACKLO = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_handshake_tx_if.sv
// Upstream valid/ready port plus the req/data/ack lines crossing to the destination domain.
interface cdc_handshake_tx_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              tx_req;
  logic [DATA_W-1:0] tx_data;
  logic              rx_ack;

  modport master (
    input  s_valid, s_data, rx_ack,
    output s_ready, tx_req, tx_data
  );

  modport slave (
    output s_valid, s_data, rx_ack,
    input  s_ready, tx_req, tx_data
  );
endinterface

// File: rtl/sync_flop.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_flop
  import cdc_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-side sender of a 4-phase req/ack multi-bit crossing: holds one word on
// tx_data while tx_req/rx_ack complete a full handshake cycle.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  cdc_handshake_tx_if.master   bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     xfer_count,
  output logic                 timeout_err
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
  localparam bit              TO_EN  = (TIMEOUT != 0);

  state_t            state;
  logic              ack_s;
  logic              s_ready;
  logic              tx_req_r;
  logic [DATA_W-1:0] tx_data_r;
  logic              busy_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              err_r;
  logic [TO_W-1:0]   to_cnt;

  sync_flop #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx_ack),
    .q   (ack_s)
  );

  // A still-high ack in IDLE means the destination has not finished the last cycle.
  assign s_ready = ~rst & (state == IDLE) & ~ack_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx_req_r  <= 1'b0;
      tx_data_r <= '0;
      busy_r    <= 1'b0;
      cnt_r     <= '0;
      err_r     <= 1'b0;
      to_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (bus.s_valid && s_ready) begin
            tx_data_r <= bus.s_data;
            tx_req_r  <= 1'b1;
            busy_r    <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            tx_req_r <= 1'b0;
            to_cnt   <= '0;
            state    <= ACKLO;
          end else if (TO_EN) begin
            if (to_cnt == TO_LIM) err_r  <= 1'b1;
            else                  to_cnt <= to_cnt + 1'b1;
          end
        end
        ACKLO: begin
          if (!ack_s) begin
            cnt_r  <= cnt_r + 1'b1;
            busy_r <= 1'b0;
            to_cnt <= '0;
            state  <= IDLE;
          end else if (TO_EN) begin
            if (to_cnt == TO_LIM) err_r  <= 1'b1;
            else                  to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          tx_req_r <= 1'b0;
          busy_r   <= 1'b0;
          to_cnt   <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready  = s_ready;
  assign bus.tx_req   = tx_req_r;
  assign bus.tx_data  = tx_data_r;
  assign busy         = busy_r;
  assign xfer_count   = cnt_r;
  assign timeout_err  = err_r;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: two instances (default and small counter/timeout)
// share stimulus; a destination responder and word queues model the protocol.
module tb_cdc_handshake_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_valid;
  logic [31:0] s_data;
  logic        resp_ack;
  logic        force_ack;
  logic        rx_ack;
  logic        sel;

  assign rx_ack = resp_ack | force_ack;

  cdc_handshake_tx_if #(.DATA_W(32)) bus0 ();
  cdc_handshake_tx_if #(.DATA_W(32)) bus1 ();

  assign bus0.s_valid = s_valid;
  assign bus0.s_data  = s_data;
  assign bus0.rx_ack  = rx_ack;
  assign bus1.s_valid = s_valid;
  assign bus1.s_data  = s_data;
  assign bus1.rx_ack  = rx_ack;

  logic        busy0, busy1, err0, err1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  localparam int TO1 = 8;

  cdc_handshake_tx #(.DATA_W(32), .CNT_W(16), .TIMEOUT(1023), .TO_W(10)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .xfer_count(cnt0), .timeout_err(err0)
  );

  cdc_handshake_tx #(.DATA_W(32), .CNT_W(4), .TIMEOUT(TO1), .TO_W(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .xfer_count(cnt1), .timeout_err(err1)
  );

  logic        tx_req_m, s_ready_m, busy_m, err_m;
  logic [31:0] tx_data_m;
  logic [15:0] cnt_m;

  assign tx_req_m  = sel ? bus1.tx_req  : bus0.tx_req;
  assign s_ready_m = sel ? bus1.s_ready : bus0.s_ready;
  assign tx_data_m = sel ? bus1.tx_data : bus0.tx_data;
  assign busy_m    = sel ? busy1 : busy0;
  assign err_m     = sel ? err1  : err0;
  assign cnt_m     = sel ? {12'd0, cnt1} : cnt0;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q  [$];
  logic [31:0] seen_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Destination-side responder: acks a rising req after a delay, releases after req falls.
  int ack_dly = 0;
  int rel_dly = 0;
  bit resp_en = 1'b0;
  bit resp_rand = 1'b0;

  initial begin
    int a;
    int r;
    resp_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (resp_en && tx_req_m && !resp_ack) begin
        a = resp_rand ? int'($urandom_range(3, 0)) : ack_dly;
        r = resp_rand ? int'($urandom_range(3, 0)) : rel_dly;
        seen_q.push_back(tx_data_m);
        for (int i = 0; i < a; i++) begin @(posedge clk); #1; end
        resp_ack = 1'b1;
        for (int i = 0; i < 300 && tx_req_m; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < r; i++) begin @(posedge clk); #1; end
        resp_ack = 1'b0;
      end
    end
  end

  // The held word may only change on an edge leaving IDLE (or by reset).
  int          viol = 0;
  logic [31:0] prev_data;
  logic        prev_busy;
  logic        prev_rst;

  always @(negedge clk) begin
    if (!rst && !prev_rst && prev_busy && (tx_data_m !== prev_data)) viol <= viol + 1;
    prev_data <= tx_data_m;
    prev_busy <= busy_m;
    prev_rst  <= rst;
  end

  task automatic wait_ack_low(input string name);
    int n = 0;
    while (rx_ack && n < 300) begin @(posedge clk); #1; n++; end
    if (rx_ack) bound_fail(name);
  endtask

  task automatic do_reset(input logic which);
    @(posedge clk); #1;
    resp_en   = 1'b0;
    resp_rand = 1'b0;
    force_ack = 1'b0;
    s_valid   = 1'b0;
    wait_ack_low("reset_ack_drain");
    rst = 1'b1;
    sel = which;
    exp_q.delete();
    seen_q.delete();
    @(negedge clk);
    chk("rst_s_ready", s_ready_m, 1'b0);
    chk("rst_tx_req", tx_req_m, 1'b0);
    chk("rst_tx_data", tx_data_m, 32'd0);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_count", cnt_m, 16'd0);
    chk("rst_err", err_m, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", s_ready_m, 1'b1);
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = w;
    do begin @(negedge clk); n++; end while (!s_ready_m && n < 300);
    if (!s_ready_m) bound_fail("send_ready");
    @(posedge clk); #1;
    s_valid = 1'b0;
    exp_q.push_back(w);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(!busy_m && s_ready_m && !rx_ack) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) bound_fail(name);
  endtask

  task automatic cmp_q(input string name);
    chk({name, "_nwords"}, 64'(seen_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
      chk({name, "_word"}, seen_q[i], exp_q[i]);
  endtask

  typedef struct {
    logic [31:0] data;
    int          ack_dly;
    int          rel_dly;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vt [3];

  initial begin
    int          n;
    int          model_cnt;
    logic [31:0] w;

    vt[0] = '{data: 32'd1, ack_dly: 0, rel_dly: 0, exp_cnt: 16'd1};
    vt[1] = '{data: 32'd2, ack_dly: 2, rel_dly: 1, exp_cnt: 16'd2};
    vt[2] = '{data: 32'd3, ack_dly: 5, rel_dly: 3, exp_cnt: 16'd3};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; force_ack = 1'b0; sel = 1'b0;

    // single transfer
    do_reset(1'b0);
    resp_en = 1'b1; ack_dly = 3; rel_dly = 1;
    send(32'hDEADBEEF);
    @(negedge clk);
    chk("t1_tx_req", tx_req_m, 1'b1);
    chk("t1_tx_data", tx_data_m, 32'hDEADBEEF);
    chk("t1_busy", busy_m, 1'b1);
    chk("t1_s_ready_busy", s_ready_m, 1'b0);
    wait_idle("t1_idle");
    chk("t1_count", cnt_m, 16'd1);
    chk("t1_busy_end", busy_m, 1'b0);
    chk("t1_s_ready_end", s_ready_m, 1'b1);
    cmp_q("t1");

    // back-to-back with s_valid held high, table driven
    do_reset(1'b0);
    resp_en = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data  = vt[i].data;
      ack_dly = vt[i].ack_dly;
      rel_dly = vt[i].rel_dly;
      n = 0;
      do begin @(negedge clk); n++; end while (!s_ready_m && n < 300);
      if (!s_ready_m) bound_fail("t2_ready");
      chk("t2_count_at_accept", cnt_m, vt[i].exp_cnt - 16'd1);
      @(posedge clk); #1;
      exp_q.push_back(vt[i].data);
      @(negedge clk);
      chk("t2_tx_data", tx_data_m, vt[i].data);
      chk("t2_tx_req", tx_req_m, 1'b1);
    end
    s_valid = 1'b0;
    wait_idle("t2_idle");
    chk("t2_count", cnt_m, vt[2].exp_cnt);
    cmp_q("t2");

    // stray ack while idle
    do_reset(1'b0);
    @(posedge clk); #1;
    force_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = 32'h12345678;
    repeat (6) @(negedge clk);
    chk("t3_s_ready", s_ready_m, 1'b0);
    chk("t3_tx_req", tx_req_m, 1'b0);
    chk("t3_busy", busy_m, 1'b0);
    chk("t3_tx_data", tx_data_m, 32'd0);
    chk("t3_err", err_m, 1'b0);
    @(posedge clk); #1;
    s_valid   = 1'b0;
    force_ack = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_ready_m && n < 20);
    chk("t3_release_latency_2_3", ((n - 1) >= 2 && (n - 1) <= 3), 1'b1);

    // timeout with no ack, then late completion
    do_reset(1'b1);
    send(32'hA5A5A5A5);
    repeat (TO1) @(posedge clk);
    @(negedge clk);
    chk("t4_err_before_limit", err_m, 1'b0);
    chk("t4_tx_req_waiting", tx_req_m, 1'b1);
    @(negedge clk);
    chk("t4_err_at_limit", err_m, 1'b1);
    repeat (20) @(negedge clk);
    chk("t4_tx_req_held", tx_req_m, 1'b1);
    chk("t4_busy_held", busy_m, 1'b1);
    resp_en = 1'b1; ack_dly = 0; rel_dly = 0;
    wait_idle("t4_idle");
    chk("t4_count", cnt_m, 16'd1);
    chk("t4_err_sticky", err_m, 1'b1);
    cmp_q("t4");

    // reset while in ACKLO
    do_reset(1'b1);
    resp_en = 1'b1; ack_dly = 1; rel_dly = 1;
    send(32'h11111111);
    wait_idle("t5_first");
    chk("t5_first_count", cnt_m, 16'd1);
    rel_dly = 20;
    send(32'h22222222);
    n = 0;
    while (tx_req_m && n < 100) begin @(negedge clk); n++; end
    if (tx_req_m) bound_fail("t5_req_fall");
    n = 0;
    while (!err_m && n < 100) begin @(negedge clk); n++; end
    chk("t5_err_in_acklo", err_m, 1'b1);
    chk("t5_busy_in_acklo", busy_m, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_tx_req", tx_req_m, 1'b0);
    chk("t5_rst_busy", busy_m, 1'b0);
    chk("t5_rst_count", cnt_m, 16'd0);
    chk("t5_rst_err", err_m, 1'b0);
    chk("t5_rst_s_ready", s_ready_m, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ack_low("t5_ack_drain");
    rel_dly = 1;
    exp_q.delete();
    seen_q.delete();
    send(32'h33333333);
    wait_idle("t5_idle");
    chk("t5_new_count", cnt_m, 16'd1);
    chk("t5_new_err", err_m, 1'b0);
    chk("t5_new_tx_data", tx_data_m, 32'h33333333);
    cmp_q("t5");

    // randomized transfers on the 4-bit counter instance, covering the wrap
    do_reset(1'b1);
    resp_en = 1'b1; resp_rand = 1'b1;
    model_cnt = 0;
    for (int k = 0; k < 17; k++) begin
      repeat ($urandom_range(3, 0)) @(posedge clk);
      w = $urandom;
      send(w);
      wait_idle("t6_idle");
      model_cnt = (model_cnt + 1) % 16;
      chk("t6_count", cnt_m, 16'(model_cnt));
    end
    chk("t6_err", err_m, 1'b0);
    cmp_q("t6");

    // randomized streaming on the default instance
    do_reset(1'b0);
    resp_en = 1'b1; resp_rand = 1'b1;
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(2, 0)) @(posedge clk);
      send($urandom);
    end
    wait_idle("t7_idle");
    chk("t7_count", cnt_m, 16'd24);
    cmp_q("t7");

    chk("tx_data_stability_violations", 64'(viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
